demux4_deser: RTL and testbench



---
 rtl/demux4_deser_pkg.sv | 14 +
 rtl/demux4_slot_ctr.sv | 28 ++
 rtl/demux4_deser.sv | 153 +++++++++++++++
 tb/tb_demux4_deser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_deser_pkg.sv
// Shared definitions for the demux4 serial receiver and its transmitter peer:
// FSM state encodings and default lane/slot widths.
package demux4_deser_pkg;

  localparam int unsigned DEF_W  = 4;
  localparam int unsigned DEF_SW = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } state_t;

endpackage

// File: rtl/demux4_slot_ctr.sv
// Lane slot counter: synchronous clear, load-1 and enable; wraps at W-1.
module demux4_slot_ctr
  import demux4_deser_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          en,
  output logic [SW-1:0] cnt
);

  localparam logic [SW-1:0] LAST = SW'(W - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SW'(1);
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + SW'(1);
    end
  end

endmodule

// File: rtl/demux4_deser.sv
// Serial-to-parallel receiver / 1-to-W demux with valid/ready output register.
// Optional even-parity bit after lane W-1 when PARITY_EN is defined.
module demux4_deser
  import demux4_deser_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  input  logic          din_sof,
  output logic [W-1:0]  w_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] slot,
  output logic          overrun,
  output logic          frame_err,
  output logic          par_err
);

  localparam logic [SW-1:0] LAST = SW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   shadow;
  logic [W-1:0]   word;
  logic [SW-1:0]  sh_idx;
  logic           sh_wr;
  logic           ctr_clr, ctr_ld1, ctr_en;
  logic           commit;
  logic           fe_set;
`ifdef PARITY_EN
  logic           pe_set;
`endif

  demux4_slot_ctr #(.W(W), .SW(SW)) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .load1 (ctr_ld1),
    .en    (ctr_en),
    .cnt   (slot)
  );

  always_comb begin
    state_d = state_q;
    sh_wr   = 1'b0;
    sh_idx  = slot;
    ctr_clr = 1'b0;
    ctr_ld1 = 1'b0;
    ctr_en  = 1'b0;
    commit  = 1'b0;
    fe_set  = 1'b0;
    // Without parity the last lane bit bypasses the shadow straight into the word.
    word    = {din, shadow[W-2:0]};
`ifdef PARITY_EN
    pe_set  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (din_valid && din_sof) begin
          sh_wr   = 1'b1;
          sh_idx  = '0;
          ctr_ld1 = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (din_valid) begin
          if (din_sof) begin
            fe_set  = 1'b1;
            sh_wr   = 1'b1;
            sh_idx  = '0;
            ctr_ld1 = 1'b1;
          end else begin
            sh_wr  = 1'b1;
            ctr_en = 1'b1;
            if (slot == LAST) begin
`ifdef PARITY_EN
              state_d = ST_PARITY;
`else
              commit  = 1'b1;
              state_d = ST_IDLE;
`endif
            end
          end
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (din_valid) begin
          if (din_sof) begin
            fe_set  = 1'b1;
            sh_wr   = 1'b1;
            sh_idx  = '0;
            ctr_ld1 = 1'b1;
            state_d = ST_COLLECT;
          end else begin
            ctr_clr = 1'b1;
            word    = shadow;
            state_d = ST_IDLE;
            if (^{shadow, din}) pe_set = 1'b1;
            else                commit = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shadow  <= '0;
    end else begin
      state_q <= state_d;
      if (sh_wr) shadow[sh_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // A commit in the same cycle as an accept overrides the clear above.
      if (commit) begin
        if (!out_valid || out_ready) begin
          w_out     <= word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (fe_set) frame_err <= 1'b1;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= pe_set;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux4_deser.sv
// Directed self-checking bench for demux4_deser (default W=4; parity steps under PARITY_EN).
module tb_demux4_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       din_sof;
  logic [3:0] w_out;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] slot;
  logic       overrun;
  logic       frame_err;
  logic       par_err;

  int checks   = 0;
  int failures = 0;

  demux4_deser #(.W(4), .SW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_sof   (din_sof),
    .w_out     (w_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot      (slot),
    .overrun   (overrun),
    .frame_err (frame_err),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic s);
    din       = b;
    din_valid = 1'b1;
    din_sof   = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  // Sends lanes w[0]..w[3] (sof on lane 0), plus a correct parity bit when enabled.
  // rdy_last raises out_ready just before the final bit of the frame.
  task automatic frame(input logic [3:0] w, input logic rdy_last);
    logic [3:0] v;
    v = w;
    bit_in(v[0], 1'b1);
    bit_in(v[1], 1'b0);
    bit_in(v[2], 1'b0);
`ifdef PARITY_EN
    bit_in(v[3], 1'b0);
    if (rdy_last) out_ready = 1'b1;
    bit_in(^v, 1'b0);
`else
    if (rdy_last) out_ready = 1'b1;
    bit_in(v[3], 1'b0);
`endif
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 1'b1;
    din_valid = 1'b1;
    din_sof   = 1'b1;
    out_ready = 1'b0;
    tick(2);
    chk("rst_w_out", w_out, 4'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_slot", slot, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_par_err", par_err, 0);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    tick(1);

    // Valid bit without sof in IDLE is ignored
    bit_in(1'b1, 1'b0);
    chk("idle_nosof_slot", slot, 0);
    chk("idle_nosof_frame_err", frame_err, 0);

    // Basic frame 0,1,1,1
    bit_in(1'b0, 1'b1);
    chk("basic_slot1", slot, 1);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("basic_no_early_valid", out_valid, 0);
    bit_in(1'b1, 1'b0);
`ifdef PARITY_EN
    chk("basic_wait_parity", out_valid, 0);
    bit_in(1'b1, 1'b0);
`endif
    chk("basic_w_out", w_out, 4'b1110);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_slot_wrap", slot, 0);
    tick(2);
    chk("basic_hold_w_out", w_out, 4'b1110);
    chk("basic_hold_valid", out_valid, 1);
    drain();
    chk("basic_accept", out_valid, 0);

    // Gapped frame 1,1,0,0 with 3 idle cycles between bits
    bit_in(1'b1, 1'b1);
    tick(3);
    chk("gap_slot_hold1", slot, 1);
    bit_in(1'b1, 1'b0);
    tick(3);
    chk("gap_slot_hold2", slot, 2);
    bit_in(1'b0, 1'b0);
    tick(3);
    chk("gap_slot_hold3", slot, 3);
    bit_in(1'b0, 1'b0);
`ifdef PARITY_EN
    tick(3);
    bit_in(1'b0, 1'b0);
`endif
    chk("gap_w_out", w_out, 4'b0011);
    chk("gap_out_valid", out_valid, 1);

    // Back-to-back frame 0,1,0,1 with out_ready held high
    out_ready = 1'b1;
    frame(4'b1010, 1'b0);
    chk("b2b_w_out", w_out, 4'b1010);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_overrun", overrun, 0);
    tick(1);
    chk("b2b_accept", out_valid, 0);
    out_ready = 1'b0;

    // Simultaneous commit and accept
    frame(4'b1001, 1'b0);
    chk("sim_first_w_out", w_out, 4'b1001);
    frame(4'b0101, 1'b1);
    out_ready = 1'b0;
    chk("sim_w_out", w_out, 4'b0101);
    chk("sim_out_valid", out_valid, 1);
    chk("sim_overrun", overrun, 0);
    drain();

    // Overrun: held word must survive a dropped frame
    frame(4'b0100, 1'b0);
    chk("ovr_first_w_out", w_out, 4'b0100);
    frame(4'b0001, 1'b0);
    chk("ovr_w_out_kept", w_out, 4'b0100);
    chk("ovr_out_valid", out_valid, 1);
    chk("ovr_overrun", overrun, 1);
    drain();
    chk("ovr_accept", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Mid-frame sof
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    chk("mid_no_err_yet", frame_err, 0);
    frame(4'b1000, 1'b0);
    chk("mid_frame_err", frame_err, 1);
    chk("mid_w_out", w_out, 4'b1000);
    chk("mid_out_valid", out_valid, 1);
    drain();

`ifdef PARITY_EN
    // Bad parity: data 1,0,1,0 with parity bit 1
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("par_bad_pulse", par_err, 1);
    chk("par_bad_no_commit", out_valid, 0);
    tick(1);
    chk("par_pulse_end", par_err, 0);
    // Good parity
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    chk("par_good_w_out", w_out, 4'b0101);
    chk("par_good_valid", out_valid, 1);
    chk("par_good_no_err", par_err, 0);
    drain();
`else
    chk("par_err_tied", par_err, 0);
`endif

    // Reset mid-frame discards everything, including sticky flags
    frame(4'b0110, 1'b0);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst2_slot", slot, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_w_out", w_out, 4'h0);
    chk("rst2_flags", {overrun, frame_err, par_err}, 3'b000);
    bit_in(1'b1, 1'b0);
    chk("rst2_idle_state", slot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
